// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, access sizes,
// fault codes and the controller state enum.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational request checker (size and fault decode) plus load-data
// extension for the latched request.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic        chk_we,
  input  logic [2:0]  chk_funct3,
  input  logic [31:0] chk_addr,
  input  logic [2:0]  ext_funct3,
  input  logic [31:0] rdata,
  output logic [1:0]  size,
  output logic [1:0]  fault,
  output logic [31:0] ext_data
);

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [32:0] nbytes;
  logic [32:0] end_addr;

  always_comb begin
    size = (chk_funct3[1:0] == 2'b11) ? SIZE_B : chk_funct3[1:0];
    case (size)
      SIZE_H:  nbytes = 33'd2;
      SIZE_W:  nbytes = 33'd4;
      default: nbytes = 33'd1;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap into range
    end_addr     = {1'b0, chk_addr} + nbytes;
    illegal      = (chk_funct3[1:0] == 2'b11) || (chk_funct3 == 3'b110) ||
                   (chk_funct3[2] && chk_we);
    misaligned   = ((size == SIZE_H) && chk_addr[0]) ||
                   ((size == SIZE_W) && (chk_addr[1:0] != 2'b00));
    out_of_range = end_addr > 33'(MEM_BYTES);

    if (illegal)           fault = FAULT_ILLEGAL;
    else if (misaligned)   fault = FAULT_MISALIGN;
    else if (out_of_range) fault = FAULT_RANGE;
    else                   fault = FAULT_NONE;

    // memory already sign-extends byte/half, so only the unsigned forms change
    case (ext_funct3)
      F3_BU:   ext_data = {24'b0, rdata[7:0]};
      F3_HU:   ext_data = {16'b0, rdata[15:0]};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request at a time, performs a single
// cycle memory access and holds the response until the consumer takes it.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic [1:0]  resp_fault,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Handshakes: a request transfers on a rising edge where req_valid and
  // req_ready are both high; a response transfers where resp_valid and
  // resp_ready are both high. resp_* stay stable while resp_valid waits.

  state_t      state, next_state;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [4:0]  lat_rd;
  logic [31:0] rdata_q;
  logic [1:0]  fault_q;
  logic        write_q;
  logic [1:0]  chk_size;
  logic [1:0]  chk_fault;
  logic [31:0] ext_data;
  logic        accept;

  lsu_align #(.MEM_BYTES(MEM_BYTES)) u_align (
    .chk_we     (req_we),
    .chk_funct3 (req_funct3),
    .chk_addr   (req_addr),
    .ext_funct3 (lat_funct3),
    .rdata      (mem_rdata),
    .size       (chk_size),
    .fault      (chk_fault),
    .ext_data   (ext_data)
  );

  assign accept = (state == ST_IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (req_valid) next_state = (chk_fault == FAULT_NONE) ? ST_ACCESS : ST_RESP;
      ST_ACCESS: next_state = ST_RESP;
      ST_RESP:   if (resp_ready) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
  end

  // write enable is a flop, set only for the single ACCESS cycle of a store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_size   <= SIZE_B;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_rd     <= 5'h0;
      rdata_q    <= 32'h0;
      fault_q    <= FAULT_NONE;
      write_q    <= 1'b0;
    end else begin
      write_q <= accept && (chk_fault == FAULT_NONE) && req_we;
      if (accept) begin
        lat_we     <= req_we;
        lat_funct3 <= req_funct3;
        lat_size   <= chk_size;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_rd     <= req_rd;
        rdata_q    <= 32'h0;
        fault_q    <= chk_fault;
      end
      if (state == ST_ACCESS) rdata_q <= lat_we ? 32'h0 : ext_data;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_rd    = lat_rd;
  assign resp_fault = fault_q;
  assign mem_write  = write_q;
  assign mem_size   = lat_size;
  assign mem_addr   = lat_addr;
  assign mem_wdata  = lat_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed and randomized bench for lsu_ctrl with a byte-array memory and a
// behavioural reference model of RV32I load/store results and faults.
module tb_lsu_ctrl;

  localparam int MEM_BYTES = 256;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_fault;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks;
  int failures;
  int wr_cycles;

  logic [7:0] mem_arr[MEM_BYTES];
  logic [7:0] ref_mem[MEM_BYTES];

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_fault (resp_fault),
    .mem_write  (mem_write),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory: asynchronous sign-extending read, byte-lane write on clk
  always_comb begin
    int a;
    logic [15:0] h;
    a = int'(mem_addr % MEM_BYTES);
    h = {mem_arr[(a + 1) % MEM_BYTES], mem_arr[a]};
    case (mem_size)
      2'b00:   mem_rdata = {{24{mem_arr[a][7]}}, mem_arr[a]};
      2'b01:   mem_rdata = {{16{h[15]}}, h};
      default: mem_rdata = {mem_arr[(a + 3) % MEM_BYTES], mem_arr[(a + 2) % MEM_BYTES], h};
    endcase
  end

  always @(posedge clk) begin
    if (mem_write === 1'b1) begin
      int a;
      int n;
      wr_cycles++;
      a = int'(mem_addr % MEM_BYTES);
      n = (mem_size == 2'b00) ? 1 : (mem_size == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++) mem_arr[(a + i) % MEM_BYTES] = 8'(mem_wdata >> (8 * i));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: fault priority and result computed from the ISA rules
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [1:0] fault,
                                output logic [31:0] rdata);
    int nbytes;
    longint last;
    bit illegal;
    logic [31:0] v;
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
    nbytes  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    last    = longint'(addr) + nbytes;
    if (illegal)                  fault = 2'd3;
    else if (addr % nbytes != 0)  fault = 2'd1;
    else if (last > MEM_BYTES)    fault = 2'd2;
    else                          fault = 2'd0;
    rdata = 32'h0;
    if (fault == 2'd0) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = 8'(wd >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        rdata = v;
      end
    end
  endfunction

  // driver: one request, response held for 'hold' cycles before acceptance
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, output logic [31:0] got);
    logic [1:0]  ef;
    logic [31:0] er;
    logic [4:0]  rd;
    rd = 5'($urandom_range(0, 31));
    model(we, f3, addr, wd, ef, er);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = rd;
    resp_ready = 1'b0;
    wr_cycles  = 0;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_rd    = 5'($urandom_range(0, 31));
    check("req_ready_busy", 32'(req_ready), 32'd0);
    if (ef == 2'd0) begin
      check("early_resp_valid", 32'(resp_valid), 32'd0);
      check("access_write", 32'(mem_write), 32'(we));
      check("access_addr", mem_addr, addr);
      check("access_size", 32'(mem_size), 32'(f3[1:0]));
      if (we) check("access_wdata", mem_wdata, wd);
      @(negedge clk);
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_write_low", 32'(mem_write), 32'd0);
    check("resp_rdata", resp_rdata, er);
    check("resp_fault", 32'(resp_fault), 32'(ef));
    check("resp_rd", 32'(resp_rd), 32'(rd));
    got = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rdata", resp_rdata, er);
      check("hold_fault", 32'(resp_fault), 32'(ef));
      check("hold_rd", 32'(resp_rd), 32'(rd));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("done_resp_valid", 32'(resp_valid), 32'd0);
    check("done_req_ready", 32'(req_ready), 32'd1);
    check("write_cycles", 32'(wr_cycles), (we && ef == 2'd0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_rd"}, 32'(resp_rd), 32'd0);
    check({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_mem_size"}, 32'(mem_size), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] ref_word;
    logic [31:0] act_word;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    checks     = 0;
    failures   = 0;
    wr_cycles  = 0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem_arr[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'h0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // directed: store/load word, byte sign/zero extension, faults, boundaries
    txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, got);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, got);
    check("lw_deadbeef", got, 32'hDEAD_BEEF);
    txn(1'b1, 3'b000, 32'h20, 32'h80, 0, got);
    txn(1'b0, 3'b000, 32'h20, 32'h0, 0, got);
    check("lb_sign", got, 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 32'h20, 32'h0, 0, got);
    check("lbu_zero", got, 32'h0000_0080);
    txn(1'b0, 3'b001, 32'h21, 32'h0, 0, got);
    txn(1'b1, 3'b010, 32'hFC, 32'h1234_5678, 0, got);
    txn(1'b0, 3'b010, 32'hFC, 32'h0, 0, got);
    check("lw_top", got, 32'h1234_5678);
    txn(1'b0, 3'b010, 32'hFD, 32'h0, 0, got);
    txn(1'b0, 3'b000, 32'h100, 32'h0, 0, got);
    txn(1'b0, 3'b011, 32'h10, 32'h0, 0, got);
    txn(1'b1, 3'b100, 32'h10, 32'h0, 0, got);
    txn(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 0, got);
    txn(1'b0, 3'b101, 32'hFE, 32'h0, 0, got);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 5, got);

    // randomized mix of sizes, alignments, ranges and back-pressure
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, MEM_BYTES + 8));
      if ($urandom_range(0, 2) != 0) addr = addr & 32'hFFFF_FFFC;
      txn(we, f3, addr, $urandom, $urandom_range(0, 3), got);
    end

    // reset during the ACCESS cycle of a store must suppress the write
    ref_word = {ref_mem[16'h33], ref_mem[16'h32], ref_mem[16'h31], ref_mem[16'h30]};
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h30;
    req_wdata  = 32'hA5A5_5A5A;
    wr_cycles  = 0;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_access", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    act_word = {mem_arr[16'h33], mem_arr[16'h32], mem_arr[16'h31], mem_arr[16'h30]};
    check("abort_mem_unchanged", act_word, ref_word);
    check("abort_write_cycles", 32'(wr_cycles), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
